// File: rtl/dff_pipe_stage.sv
// One register stage of the elastic pipeline: a data word plus its valid bit.
// Load wins over advance; flush clears valid but leaves the data word alone.
module dff_pipe_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (advance) begin
      // Word moved on and nothing replaced it; q is now a don't-care.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready handshake,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CountW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            can_load;
  logic [DEPTH-1:0]            advance;
  logic [DEPTH-1:0]            load;
  logic [DEPTH-1:0]            valid_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [CountW-1:0]           count_d;
  logic [CountW-1:0]           count_q;

  // The ready chain ripples from the output stage back to the input in one pass.
  always_comb begin
    advance   = '0;
    can_load  = '0;
    load      = '0;
    valid_nxt = '0;
    count_d   = '0;

    advance[DEPTH-1]  = valid[DEPTH-1] & out_ready;
    can_load[DEPTH-1] = ~valid[DEPTH-1] | advance[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      advance[i]  = valid[i] & can_load[i+1];
      can_load[i] = ~valid[i] | advance[i];
    end

    in_ready = can_load[0] & ~flush & rst_n;
    load[0]  = in_valid & in_ready;
    for (int i = 1; i < int'(DEPTH); i++) begin
      load[i] = advance[i-1];
    end

    if (rst_n && !flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        valid_nxt[i] = load[i] | (valid[i] & ~advance[i]);
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CountW'(valid_nxt[i]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] stage_d;
    if (g == 0) begin : g_head
      assign stage_d = in_data;
    end else begin : g_body
      assign stage_d = stage_q[g-1];
    end

    dff_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .load    (load[g]),
      .advance (advance[g]),
      .d       (stage_d),
      .q       (stage_q[g]),
      .valid   (valid[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = stage_q[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a DEPTH=2 and a DEPTH=3 instance share stimulus, each
// with its own scoreboard queue checked whenever an output word fires.
module tb_dff_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;
  logic       flush;

  logic       a_in_ready, a_out_valid;
  logic [3:0] a_out_data;
  logic [1:0] a_count;
  logic       b_in_ready, b_out_valid;
  logic [3:0] b_out_data;
  logic [1:0] b_count;

  int total;
  int bad;
  logic [3:0] qa[$];
  logic [3:0] qb[$];

  dff_pipe #(
    .WIDTH (4),
    .DEPTH (2)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data),
    .flush     (flush),
    .count     (a_count)
  );

  dff_pipe #(
    .WIDTH (4),
    .DEPTH (3)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data),
    .flush     (flush),
    .count     (b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle: scoreboard both DUTs at the falling edge, then return
  // just after the next rising edge so callers can drive new inputs.
  task automatic tick();
    logic [3:0] exp_w;
    @(negedge clk);
    if (rst_n && !flush && a_out_valid && out_ready) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL sb_a: got unexpected word %h, required no output", a_out_data);
      end else begin
        exp_w = qa.pop_front();
        if (a_out_data !== exp_w) begin
          bad++;
          $display("FAIL sb_a: got %h, required %h", a_out_data, exp_w);
        end
      end
    end
    if (rst_n && !flush && b_out_valid && out_ready) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL sb_b: got unexpected word %h, required no output", b_out_data);
      end else begin
        exp_w = qb.pop_front();
        if (b_out_data !== exp_w) begin
          bad++;
          $display("FAIL sb_b: got %h, required %h", b_out_data, exp_w);
        end
      end
    end
    if (rst_n && !flush && in_valid && a_in_ready) qa.push_back(in_data);
    if (rst_n && !flush && in_valid && b_in_ready) qb.push_back(in_data);
    if (!rst_n || flush) begin
      qa.delete();
      qb.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    total++;
    if (a_count !== 2'd0 || b_count !== 2'd0) begin
      bad++;
      $display("FAIL drain_count: got a=%0d b=%0d, required 0 0", a_count, b_count);
    end
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain_lost: words undelivered a=%0d b=%0d, required 0 0",
               qa.size(), qb.size());
    end
    total++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_valid: got a=%b b=%b, required 0 0", a_out_valid, b_out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'hF;
    out_ready = 1'b0;
    flush     = 1'b0;
    tick();
    tick();
    total++;
    if (a_out_valid !== 1'b0 || a_out_data !== 4'h0 || a_count !== 2'd0) begin
      bad++;
      $display("FAIL reset_a: got valid=%b data=%h count=%0d, required 0 0 0",
               a_out_valid, a_out_data, a_count);
    end
    total++;
    if (b_out_valid !== 1'b0 || b_out_data !== 4'h0 || b_count !== 2'd0) begin
      bad++;
      $display("FAIL reset_b: got valid=%b data=%h count=%0d, required 0 0 0",
               b_out_valid, b_out_data, b_count);
    end
    total++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready: got a=%b b=%b, required 0 0", a_in_ready, b_in_ready);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    total++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_in_ready: got a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [4:0] exp_v;
    logic [3:0] exp_d[5];
    exp_v = 5'b11100;  // bit c: out_valid expected in cycle c
    exp_d[0] = 4'h0; exp_d[1] = 4'h0; exp_d[2] = 4'h1; exp_d[3] = 4'h2; exp_d[4] = 4'h3;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 3);
      in_data  = 4'(c + 1);
      #1;
      total++;
      if (a_out_valid !== exp_v[c] || (exp_v[c] && a_out_data !== exp_d[c])) begin
        bad++;
        $display("FAIL stream_c%0d: got valid=%b data=%h, required valid=%b data=%h",
                 c, a_out_valid, a_out_data, exp_v[c], exp_d[c]);
      end
      tick();
    end
    test_drain();
  endtask

  task automatic test_stall();
    logic [3:0] words[3];
    words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC;
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_data  = words[c];
      #1;
      total++;
      if (a_in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stall_accept%0d: got in_ready=%b, required 1", c, a_in_ready);
      end
      tick();
    end
    in_data = words[2];
    #1;
    total++;
    if (a_in_ready !== 1'b0 || a_count !== 2'd2) begin
      bad++;
      $display("FAIL stall_full: got in_ready=%b count=%0d, required 0 2", a_in_ready, a_count);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) in_valid = 1'b0;
      #1;
      total++;
      if (a_out_valid !== 1'b1 || a_out_data !== words[c]) begin
        bad++;
        $display("FAIL stall_order%0d: got valid=%b data=%h, required 1 %h",
                 c, a_out_valid, a_out_data, words[c]);
      end
      tick();
    end
    test_drain();
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 4'h5; tick();
    in_valid  = 1'b0;                 tick();
    in_valid  = 1'b1; in_data = 4'h6; tick();
    in_valid  = 1'b0;                 tick();
    #1;
    total++;
    if (b_count !== 2'd2 || b_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bubble_pack: got count=%0d in_ready=%b, required 2 1", b_count, b_in_ready);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (b_out_valid !== 1'b1 || b_out_data !== 4'h5) begin
      bad++;
      $display("FAIL bubble_head: got valid=%b data=%h, required 1 5", b_out_valid, b_out_data);
    end
    tick();
    // The second word must already sit in stage 1 to emerge right behind the first.
    total++;
    if (b_out_valid !== 1'b1 || b_out_data !== 4'h6) begin
      bad++;
      $display("FAIL bubble_next: got valid=%b data=%h, required 1 6", b_out_valid, b_out_data);
    end
    test_drain();
  endtask

  task automatic test_full_simul();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 4'h7; tick();
    in_data   = 4'h8; tick();
    in_data   = 4'h9;
    #1;
    total++;
    if (a_count !== 2'd2 || a_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_stall: got count=%0d in_ready=%b, required 2 0", a_count, a_in_ready);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 1'b1 || a_out_data !== 4'h7) begin
      bad++;
      $display("FAIL full_pass: got in_ready=%b data=%h, required 1 7", a_in_ready, a_out_data);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    total++;
    if (a_count !== 2'd2 || a_out_data !== 4'h8) begin
      bad++;
      $display("FAIL full_simul: got count=%0d data=%h, required 2 8", a_count, a_out_data);
    end
    test_drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 4'h1; tick();
    in_data   = 4'h2; tick();
    in_valid  = 1'b0;
    #1;
    total++;
    if (a_count !== 2'd2) begin
      bad++;
      $display("FAIL flush_pre: got count=%0d, required 2", a_count);
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'hE;
    out_ready = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_in_ready: got a=%b b=%b, required 0 0", a_in_ready, b_in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (a_count !== 2'd0 || a_out_valid !== 1'b0 || b_count !== 2'd0 || b_out_valid !== 1'b0)
    begin
      bad++;
      $display("FAIL flush_clear: got a count=%0d valid=%b b count=%0d valid=%b, required 0s",
               a_count, a_out_valid, b_count, b_out_valid);
    end
    repeat (3) tick();
    total++;
    if (a_out_valid !== 1'b0 || a_out_data !== 4'h1) begin
      bad++;
      $display("FAIL flush_nostore: got valid=%b data=%h, required 0 1", a_out_valid, a_out_data);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 4'h3; tick();
    in_data   = 4'h4; tick();
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    #1;
    total++;
    if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== 4'h0) begin
      bad++;
      $display("FAIL reset_mid: got count=%0d valid=%b data=%h, required 0 0 0",
               a_count, a_out_valid, a_out_data);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    test_drain();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_bubble();
    test_full_simul();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
